// File: rtl/riscv_v_mask_alu_ctrl.sv
// Sequencer for the vector mask logical unit.
// One instruction in flight: reads vs1, vs2 and old vd over a shared read
// port, drives the mask ALU, merges the result with old vd under vl
// (tail-undisturbed) and writes back through a ready/valid port.
module riscv_v_mask_alu_ctrl #(
  parameter int MASK_W = 128,
  parameter int VL_W   = $clog2(MASK_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_vs1,
  input  logic [4:0]        req_vs2,
  input  logic [4:0]        req_vd,
  input  logic [VL_W-1:0]   req_vl,
  output logic              rf_rd_en,
  output logic [4:0]        rf_rd_addr,
  input  logic [MASK_W-1:0] rf_rd_data,
  output logic              alu_is_mask,
  output logic              alu_is_and,
  output logic              alu_is_or,
  output logic              alu_is_xor,
  output logic              alu_is_negate_srca,
  output logic              alu_is_negate_result,
  output logic [MASK_W-1:0] alu_srca,
  output logic [MASK_W-1:0] alu_srcb,
  input  logic [MASK_W-1:0] alu_result,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [4:0]        wr_addr,
  output logic [MASK_W-1:0] wr_data,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_VS1 = 3'd1,
    RD_VS2 = 3'd2,
    RD_VD  = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5
  } state_e;

  localparam logic [VL_W-1:0] VL_MAX = VL_W'(MASK_W);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        vs1_idx_q, vs2_idx_q, vd_idx_q;
  logic [VL_W-1:0]   vl_q;
  logic [MASK_W-1:0] vs1_q, vs2_q, wr_data_q;
  logic              done_pend_q;

  logic              can_accept;
  logic              accept;
  logic [VL_W-1:0]   vl_clamp;
  logic [MASK_W-1:0] merged;

  // A zero-length request still owes a done pulse next cycle, so hold off
  // new requests until it has been delivered.
  assign can_accept = (state_q == IDLE) && !done_pend_q;
  assign accept     = req_valid && can_accept;
  assign vl_clamp   = (req_vl > VL_MAX) ? VL_MAX : req_vl;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed read sequence, then stall in WB on wr_ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (vl_clamp == '0) ? IDLE : RD_VS1;
      RD_VS1:  state_d = RD_VS2;
      RD_VS2:  state_d = RD_VD;
      RD_VD:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      if (wr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is gated by state so reset forces it to zero
  always_comb begin
    req_ready            = can_accept;
    rf_rd_en             = 1'b0;
    rf_rd_addr           = '0;
    alu_is_mask          = 1'b0;
    alu_is_and           = 1'b0;
    alu_is_or            = 1'b0;
    alu_is_xor           = 1'b0;
    alu_is_negate_srca   = 1'b0;
    alu_is_negate_result = 1'b0;
    alu_srca             = '0;
    alu_srcb             = '0;
    wr_valid             = 1'b0;
    wr_addr              = '0;
    wr_data              = '0;
    done                 = done_pend_q;
    unique case (state_q)
      RD_VS1: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = vs1_idx_q;
      end
      RD_VS2: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = vs2_idx_q;
      end
      RD_VD: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = vd_idx_q;
      end
      EXEC: begin
        alu_is_mask = 1'b1;
        alu_srca    = vs1_q;
        alu_srcb    = vs2_q;
        // op[2]: OR family; 011/111: XOR family; else AND family
        alu_is_xor           = (op_q[1:0] == 2'b11);
        alu_is_or            = op_q[2] && (op_q[1:0] != 2'b11);
        alu_is_and           = !op_q[2] && (op_q[1:0] != 2'b11);
        alu_is_negate_srca   = (op_q[1:0] == 2'b10);
        alu_is_negate_result = (op_q == 3'b001) || (op_q == 3'b101) ||
                               (op_q == 3'b111);
      end
      WB: begin
        wr_valid = 1'b1;
        wr_addr  = vd_idx_q;
        wr_data  = wr_data_q;
        done     = wr_ready;
      end
      default: ;
    endcase
  end

  // Tail-undisturbed merge: body bits from the ALU, tail bits from old vd,
  // which is on the read port during EXEC
  always_comb begin
    merged = '0;
    for (int i = 0; i < MASK_W; i++)
      merged[i] = (i < int'(vl_q)) ? alu_result[i] : rf_rd_data[i];
  end

  // Request latch, operand capture and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      vs1_idx_q   <= '0;
      vs2_idx_q   <= '0;
      vd_idx_q    <= '0;
      vl_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      wr_data_q   <= '0;
      done_pend_q <= 1'b0;
    end else begin
      done_pend_q <= accept && (vl_clamp == '0);
      if (accept) begin
        op_q      <= req_op;
        vs1_idx_q <= req_vs1;
        vs2_idx_q <= req_vs2;
        vd_idx_q  <= req_vd;
        vl_q      <= vl_clamp;
      end
      if (state_q == RD_VS2) vs1_q     <= rf_rd_data;
      if (state_q == RD_VD)  vs2_q     <= rf_rd_data;
      if (state_q == EXEC)   wr_data_q <= merged;
    end
  end

endmodule

// File: tb/tb_riscv_v_mask_alu_ctrl.sv
// Bench for riscv_v_mask_alu_ctrl: register-file and ALU models around the
// DUT, expected write-backs queued at issue and popped at the handshake.
module tb_riscv_v_mask_alu_ctrl;
  localparam int W = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_op = '0;
  logic [4:0] req_vs1 = '0, req_vs2 = '0, req_vd = '0;
  logic [7:0] req_vl = '0;
  logic rf_rd_en;
  logic [4:0] rf_rd_addr;
  logic [W-1:0] rf_rd_data;
  logic a_mask, a_and, a_or, a_xor, a_nsa, a_nres;
  logic [W-1:0] alu_srca, alu_srcb, alu_result;
  logic wr_valid, wr_ready = 1'b1, done;
  logic [4:0] wr_addr;
  logic [W-1:0] wr_data;

  logic tb_we = 1'b0;
  logic [4:0] tb_widx = '0;
  logic [W-1:0] tb_wdata = '0;
  logic [W-1:0] rf [32];
  int wr_cnt = 0;

  typedef struct { logic [4:0] addr; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  riscv_v_mask_alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .req_vl(req_vl), .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .alu_is_mask(a_mask), .alu_is_and(a_and),
    .alu_is_or(a_or), .alu_is_xor(a_xor), .alu_is_negate_srca(a_nsa),
    .alu_is_negate_result(a_nres), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_result(alu_result), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  // Register file: 1-cycle read, write port shared by DUT and preload
  always @(posedge clk) begin
    rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : '0;
    if (tb_we) rf[tb_widx] <= tb_wdata;
    if (wr_valid && wr_ready) begin
      rf[wr_addr] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Mask ALU model driven by the DUT controls
  always_comb begin
    logic [W-1:0] ae, r;
    ae = a_nsa ? ~alu_srca : alu_srca;
    r = '0;
    if (a_and) r = ae & alu_srcb;
    else if (a_or) r = ae | alu_srcb;
    else if (a_xor) r = ae ^ alu_srcb;
    alu_result = a_nres ? ~r : r;
  end

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] idx, input logic [W-1:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_widx = idx; tb_wdata = val;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic junk_fields();
    req_op = 3'($urandom); req_vs1 = 5'($urandom); req_vs2 = 5'($urandom);
    req_vd = 5'($urandom); req_vl = 8'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, W'({rf_rd_en, rf_rd_addr, wr_valid, wr_addr, a_mask, a_and,
                          a_or, a_xor, a_nsa, a_nres, done}), '0);
    chk({tag, "_wd"}, wr_data, '0);
    chk({tag, "_src"}, alu_srca | alu_srcb, '0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [7:0] vl, input int stall,
                        input bit abort);
    logic [W-1:0] a, b, o, r, m, e;
    logic [4:0] ctl;
    int vle, w0;
    exp_t got;
    @(negedge clk);
    chk("idle_ready", W'(req_ready), W'(1));
    a = rf[s1]; b = rf[s2]; o = rf[d];
    vle = (vl > 8'd128) ? 128 : int'(vl);
    case (op)
      3'd0: begin r = a & b;     ctl = 5'b10000; end
      3'd1: begin r = ~(a & b);  ctl = 5'b10001; end
      3'd2: begin r = b & ~a;    ctl = 5'b10010; end
      3'd3: begin r = a ^ b;     ctl = 5'b00100; end
      3'd4: begin r = a | b;     ctl = 5'b01000; end
      3'd5: begin r = ~(a | b);  ctl = 5'b01001; end
      3'd6: begin r = b | ~a;    ctl = 5'b01010; end
      default: begin r = ~(a ^ b); ctl = 5'b00101; end
    endcase
    m = '0;
    for (int i = 0; i < vle; i++) m[i] = 1'b1;
    e = (r & m) | (o & ~m);
    req_valid = 1'b1; req_op = op; req_vs1 = s1; req_vs2 = s2; req_vd = d; req_vl = vl;
    if (vle == 0) begin
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0; junk_fields();
      chk("vl0_done", W'({done, rf_rd_en, wr_valid, req_ready}), W'(4'b1000));
      @(negedge clk);
      chk("vl0_after", W'({done, rf_rd_en, wr_valid, req_ready}), W'(4'b0001));
      chk("vl0_nowrite", W'(wr_cnt), W'(w0));
      return;
    end
    exp_q.push_back('{d, e});
    @(negedge clk);
    req_valid = 1'b0; junk_fields();
    chk("rd_vs1", W'({rf_rd_en, rf_rd_addr, req_ready, done}), W'({1'b1, s1, 2'b00}));
    @(negedge clk);
    chk("rd_vs2", W'({rf_rd_en, rf_rd_addr}), W'({1'b1, s2}));
    @(negedge clk);
    chk("rd_vd", W'({rf_rd_en, rf_rd_addr}), W'({1'b1, d}));
    if (abort) begin
      w0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      chk_quiet("abort");
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("abort_idle", W'({req_ready, done, wr_valid, rf_rd_en}), W'(4'b1000));
      end
      chk("abort_nowrite", W'(wr_cnt), W'(w0));
      return;
    end
    @(negedge clk);
    chk("exec_ctl", W'({a_mask, a_and, a_or, a_xor, a_nsa, a_nres}), W'({1'b1, ctl}));
    chk("exec_srca", alu_srca, a);
    chk("exec_srcb", alu_srcb, b);
    chk("exec_quiet", W'({rf_rd_en, wr_valid, done}), '0);
    if (stall > 0) wr_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      req_valid = 1'b1; junk_fields();
      chk("stall_ctl", W'({wr_valid, wr_addr, done, req_ready}), W'({1'b1, d, 2'b00}));
      chk("stall_data", wr_data, e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    wr_ready = 1'b1;
    #1;
    chk("wb_done", W'({wr_valid, done, a_mask}), W'(3'b110));
    if (exp_q.size() == 0) chk("sb_empty", W'(1), W'(0));
    else begin
      got = exp_q.pop_front();
      chk("wb_addr", W'(wr_addr), W'(got.addr));
      chk("wb_data", wr_data, got.data);
    end
  endtask

  initial begin
    #1;
    chk_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", W'(req_ready), W'(1));
    chk_quiet("post_reset");

    // AND with alternating patterns
    set_reg(5'd1, {16{8'hF0}});
    set_reg(5'd2, {8{16'hFF00}});
    set_reg(5'd3, {4{32'h1234_5678}});
    run_op(3'd0, 5'd1, 5'd2, 5'd3, 8'd128, 0, 1'b0);
    // ANDN and XNOR back-to-back
    set_reg(5'd4, 128'h0F);
    set_reg(5'd5, 128'hFF);
    run_op(3'd2, 5'd4, 5'd5, 5'd6, 8'd128, 0, 1'b0);
    run_op(3'd7, 5'd4, 5'd5, 5'd7, 8'd128, 0, 1'b0);
    // NOR tail-undisturbed, old vd ones then zeros
    set_reg(5'd8, '0);
    set_reg(5'd9, '1);
    set_reg(5'd10, '0);
    run_op(3'd5, 5'd8, 5'd8, 5'd9, 8'd8, 0, 1'b0);
    run_op(3'd5, 5'd8, 5'd8, 5'd10, 8'd8, 0, 1'b0);
    // vl = 0 and clamped vl
    set_reg(5'd12, {$urandom, $urandom, $urandom, $urandom});
    set_reg(5'd13, {$urandom, $urandom, $urandom, $urandom});
    set_reg(5'd14, {$urandom, $urandom, $urandom, $urandom});
    run_op(3'd3, 5'd12, 5'd13, 5'd14, 8'd0, 0, 1'b0);
    run_op(3'd3, 5'd12, 5'd13, 5'd14, 8'd200, 0, 1'b0);
    // Stalled write-back, then back-to-back aliased ops
    run_op(3'd4, 5'd12, 5'd13, 5'd15, 8'd77, 3, 1'b0);
    run_op(3'd6, 5'd15, 5'd12, 5'd15, 8'd127, 0, 1'b0);
    run_op(3'd1, 5'd13, 5'd13, 5'd13, 8'd1, 1, 1'b0);
    // Abort during RD_VD, then a normal op
    run_op(3'd0, 5'd12, 5'd13, 5'd16, 8'd128, 0, 1'b1);
    run_op(3'd0, 5'd12, 5'd13, 5'd16, 8'd100, 0, 1'b0);
    // Random mix
    for (int i = 17; i < 24; i++)
      set_reg(5'(i), {$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 8; n++)
      run_op(3'($urandom), 5'($urandom_range(17, 23)), 5'($urandom_range(17, 23)),
             5'($urandom_range(17, 23)), 8'($urandom_range(0, 140)),
             $urandom_range(0, 2), 1'b0);
    chk("sb_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_v_mask_alu_ctrl.md
# riscv_v_mask_alu_ctrl

Sequencer for the vector mask logical unit (vmand/vmnand/vmandn/vmxor/vmor/vmnor/vmorn/vmxnor). It accepts one mask instruction at a time, fetches vs1, vs2 and the old vd over a shared single-port mask register-file read port, and drives the mask ALU control and source signals. It merges the ALU result with the old vd under vl (tail-undisturbed) and writes the merged value back through a ready/valid write port.

## Interface
- MASK_W, 128, mask register width in bits (= VLEN); the ALU srca/srcb/result width.
- VL_W, $clog2(MASK_W)+1, width of vl.
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  instruction request valid
- req_ready  output  1  controller can accept; high only in IDLE
- req_op  input  3  000 AND, 001 NAND, 010 ANDN, 011 XOR, 100 OR, 101 NOR, 110 ORN, 111 XNOR
- req_vs1, req_vs2, req_vd  input  5 each  register indices
- req_vl  input  VL_W  active element count
- rf_rd_en  output  1  read strobe
- rf_rd_addr  output  5  read index
- rf_rd_data  input  MASK_W  read data, valid exactly 1 cycle after rf_rd_en
- alu_is_mask, alu_is_and, alu_is_or, alu_is_xor, alu_is_negate_srca, alu_is_negate_result  output  1 each  ALU controls
- alu_srca, alu_srcb  output  MASK_W  srca = vs1, srcb = vs2
- alu_result  input  MASK_W  combinational ALU result, same cycle as controls
- wr_valid  output  1  write-back valid
- wr_ready  input  1  register file accepts write
- wr_addr  output  5  = vd
- wr_data  output  MASK_W  merged result
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, RD_VS1, RD_VS2, RD_VD, EXEC, WB.
- IDLE: req_ready=1. On req_valid, latch op, vs1, vs2, vd, and vl_eff = min(req_vl, MASK_W).
  - vl_eff==0: go to IDLE, pulse done next cycle; no reads, no write.
  - Otherwise go to RD_VS1.
- RD_VS1: rf_rd_en=1, addr=vs1. Go to RD_VS2.
- RD_VS2: rf_rd_en=1, addr=vs2; capture rf_rd_data into vs1 register. Go to RD_VD.
- RD_VD: rf_rd_en=1, addr=vd; capture vs2. Go to EXEC.
- EXEC:
  - Use rf_rd_data (old vd) directly.
  - Drive alu_is_mask=1 plus decoded controls, alu_srca=vs1, alu_srcb=vs2.
  - Register wr_data[i] = (i < vl_eff) ? alu_result[i] : old_vd[i]. Go to WB.
- Decode:
  - AND: and
  - NAND: and + negate_result
  - ANDN: and + negate_srca (vs2 & ~vs1)
  - XOR: xor
  - OR: or
  - NOR: or + negate_result
  - ORN: or + negate_srca
  - XNOR: xor + negate_result
  - Exactly one of and/or/xor is high in EXEC.
- WB: wr_valid=1, wr_addr=vd, wr_data stable until wr_ready. On wr_valid&wr_ready, pulse done in the same cycle and go to IDLE.
- Aliasing (vd==vs1 or vd==vs2, or vs1==vs2) is legal. Reads are always issued; no forwarding is needed because there is one instruction in flight.
- Outside EXEC, all alu_* outputs are 0. rf_rd_en is 0 outside the RD_* states. wr_valid is 0 outside WB.

## Timing
- Reset (async assert, sync release): state IDLE. Outputs:
  - req_ready=1 once released.
  - All other outputs 0, including rf_rd_addr, wr_addr, wr_data and alu_srca/srcb.
- Reset mid-operation aborts immediately: no write, no done pulse.
- Accept at cycle 0. Then:
  - RD_VS1 cycle 1, RD_VS2 cycle 2, RD_VD cycle 3, EXEC cycle 4.
  - WB from cycle 5; with wr_ready=1, done at cycle 5.
  - Earliest next accept at cycle 6. Each wr_ready stall cycle adds one cycle.
- vl_eff==0: accept cycle 0, done cycle 1, req_ready at cycle 2.
- req_valid while not IDLE is ignored (req_ready=0). Request fields are sampled only on the accept cycle.
- vl boundary:
  - vl_eff==MASK_W: no old-vd bits survive.
  - req_vl > MASK_W is clamped.

## Test plan
- AND, vs1=0xF0F0…, vs2=0xFF00…, vl=128 -> EXEC controls is_and=1 only; wr_data=0xF000…; done at cycle 5.
- ANDN and XNOR with vs1=0x0…0F, vs2=0x0…FF, vl=128 -> controls:
  - ANDN: and+negate_srca, wr_data=0x0…F0.
  - XNOR: xor+negate_result, wr_data=0xF…F0F.
- NOR, vs1=vs2=0, old vd=all-ones, vl=8 -> wr_data = low 8 bits ones (result), upper 120 bits ones (old vd). Repeat with old vd=0: wr_data=0x00…FF.
- vl=0 and vl=200 -> vl=0: no rf_rd_en, no wr_valid, done at cycle 1. vl=200: treated as 128.
- wr_ready held low 3 cycles in WB -> wr_valid/wr_data/wr_addr stable; req_ready=0; done only on the handshake cycle. Back-to-back request accepted the cycle after done.
- rst_n asserted during RD_VD -> all outputs 0 asynchronously; no write after release; next request completes normally.
